// File: rtl/axis_eth_fcs_multi_if.sv
// Input AXI-Stream bundle for the Ethernet FCS block. The producer drives the
// frame beats and the FCS block drives tready.
interface axis_eth_fcs_multi_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_eth_fcs_multi.sv
// Ethernet CRC-32 over an AXI-Stream frame, either generating the FCS or checking
// a received one, with a held result handshake and frame/bad-frame statistics.

// Combinational reflected Galois LFSR step over DATA_WIDTH bits, LSB first.
module ve_lfsr #(
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04C11DB7,
  parameter int                    DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);
  function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_R = reflect(LFSR_POLY);

  logic [LFSR_WIDTH-1:0] state_v;

  // NOTE: blocking assignments here on purpose -- each loop pass must see the
  // previous pass's value, which builds the unrolled XOR network.
  always_comb begin
    state_v = state_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (state_v[0] ^ data_in[i]) state_v = (state_v >> 1) ^ POLY_R;
      else                         state_v = state_v >> 1;
    end
    state_out = state_v;
  end
endmodule

module axis_eth_fcs_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter bit CHECK_MODE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axis_eth_fcs_multi_if.slave    s_axis,
  output logic [31:0]            m_fcs,
  output logic [15:0]            m_fcs_len,
  output logic                   m_fcs_bad,
  output logic                   m_fcs_valid,
  input  logic                   m_fcs_ready,
  output logic [31:0]            stat_frames,
  output logic [31:0]            stat_bad
);
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] fcs_q;
  logic [15:0] len_q;
  logic        bad_q, valid_q;
  logic [31:0] frames_q, nbad_q;

  logic        beat_fire, result_fire;
  logic [15:0] n_bytes, len_sat;
  logic [16:0] len_sum;
  logic [31:0] crc_sel, fcs_new;
  logic        bad_new;

  // Index k holds the CRC state after absorbing the low k bytes of this beat.
  logic [31:0] crc_by_len [KEEP_WIDTH+1];

  assign crc_by_len[0] = crc_q;

  ve_lfsr #(.LFSR_WIDTH(32), .LFSR_POLY(CRC_POLY), .DATA_WIDTH(DATA_WIDTH)) u_lfsr_full (
    .data_in   (s_axis.tdata),
    .state_in  (crc_q),
    .state_out (crc_by_len[KEEP_WIDTH])
  );

  for (genvar k = 1; k < KEEP_WIDTH; k++) begin : g_part
    ve_lfsr #(.LFSR_WIDTH(32), .LFSR_POLY(CRC_POLY), .DATA_WIDTH(8*k)) u_lfsr_part (
      .data_in   (s_axis.tdata[8*k-1:0]),
      .state_in  (crc_q),
      .state_out (crc_by_len[k])
    );
  end

  assign s_axis.tready = !(valid_q && !m_fcs_ready);
  assign beat_fire     = s_axis.tvalid && s_axis.tready;
  assign result_fire   = valid_q && m_fcs_ready;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    n_bytes = 16'(KEEP_WIDTH);
    if (s_axis.tlast) begin
      n_bytes = '0;
      for (int i = 0; i < KEEP_WIDTH; i++)
        if (s_axis.tkeep[i]) n_bytes = n_bytes + 16'd1;
    end

    crc_sel = crc_q;
    for (int k = 0; k <= KEEP_WIDTH; k++)
      if (n_bytes == 16'(k)) crc_sel = crc_by_len[k];

    len_sum = {1'b0, cnt_q} + {1'b0, n_bytes};
    len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];

    fcs_new = CHECK_MODE ? crc_sel : ~crc_sel;
    bad_new = s_axis.tuser |
              (CHECK_MODE & ((crc_sel != CRC_RESIDUE) | (len_sat < 16'd4)));

    crc_d = crc_q;
    cnt_d = cnt_q;
    if (beat_fire) begin
      crc_d = s_axis.tlast ? CRC_INIT : crc_sel;
      cnt_d = s_axis.tlast ? 16'd0    : len_sat;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q    <= CRC_INIT;
      cnt_q    <= '0;
      fcs_q    <= '0;
      len_q    <= '0;
      bad_q    <= 1'b0;
      valid_q  <= 1'b0;
      frames_q <= '0;
      nbad_q   <= '0;
    end else begin
      crc_q <= crc_d;
      cnt_q <= cnt_d;
      // A new last beat wins over the clear so back-to-back results keep valid high.
      if (beat_fire && s_axis.tlast) begin
        fcs_q   <= fcs_new;
        len_q   <= len_sat;
        bad_q   <= bad_new;
        valid_q <= 1'b1;
      end else if (result_fire) begin
        valid_q <= 1'b0;
      end
      if (result_fire) begin
        frames_q <= frames_q + 32'd1;
        if (bad_q) nbad_q <= nbad_q + 32'd1;
      end
    end
  end

  assign m_fcs       = fcs_q;
  assign m_fcs_len   = len_q;
  assign m_fcs_bad   = bad_q;
  assign m_fcs_valid = valid_q;
  assign stat_frames = frames_q;
  assign stat_bad    = nbad_q;
endmodule

// File: tb/tb_axis_eth_fcs_multi.sv
// Directed bench: 8-bit and 32-bit generators and a 64-bit checker, driven with
// "123456789" and other frames whose CRC-32 values are known by hand.
`timescale 1ns/1ps
module tb_axis_eth_fcs_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  axis_eth_fcs_multi_if #(.DATA_WIDTH(8))  if8 ();
  axis_eth_fcs_multi_if #(.DATA_WIDTH(32)) if32 ();
  axis_eth_fcs_multi_if #(.DATA_WIDTH(64)) if64 ();

  logic [31:0] fcs8, fcs32, fcs64;
  logic [15:0] len8, len32, len64;
  logic        bad8, bad32, bad64, val8, val32, val64;
  logic        rdy8, rdy32, rdy64;
  logic [31:0] fr8, fr32, fr64, sb8, sb32, sb64;

  axis_eth_fcs_multi #(.DATA_WIDTH(8), .CHECK_MODE(1'b0)) u_gen8 (
    .clk(clk), .rst_n(rst_n), .s_axis(if8),
    .m_fcs(fcs8), .m_fcs_len(len8), .m_fcs_bad(bad8), .m_fcs_valid(val8),
    .m_fcs_ready(rdy8), .stat_frames(fr8), .stat_bad(sb8));

  axis_eth_fcs_multi #(.DATA_WIDTH(32), .CHECK_MODE(1'b0)) u_gen32 (
    .clk(clk), .rst_n(rst_n), .s_axis(if32),
    .m_fcs(fcs32), .m_fcs_len(len32), .m_fcs_bad(bad32), .m_fcs_valid(val32),
    .m_fcs_ready(rdy32), .stat_frames(fr32), .stat_bad(sb32));

  axis_eth_fcs_multi #(.DATA_WIDTH(64), .CHECK_MODE(1'b1)) u_chk64 (
    .clk(clk), .rst_n(rst_n), .s_axis(if64),
    .m_fcs(fcs64), .m_fcs_len(len64), .m_fcs_bad(bad64), .m_fcs_valid(val64),
    .m_fcs_ready(rdy64), .stat_frames(fr64), .stat_bad(sb64));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Each send starts at a falling edge and returns at the falling edge after acceptance.
  task automatic send8(input logic [7:0] d, input logic l, input logic u);
    if8.tdata = d; if8.tkeep = 1'b1; if8.tlast = l; if8.tuser = u; if8.tvalid = 1'b1;
    for (int w = 0; w < 100 && !if8.tready; w++) @(negedge clk);
    check("tready8_wait", 64'(if8.tready), 64'd1);
    @(posedge clk); @(negedge clk);
    if8.tvalid = 1'b0; if8.tlast = 1'b0; if8.tuser = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    if32.tdata = d; if32.tkeep = k; if32.tlast = l; if32.tuser = u; if32.tvalid = 1'b1;
    for (int w = 0; w < 100 && !if32.tready; w++) @(negedge clk);
    check("tready32_wait", 64'(if32.tready), 64'd1);
    @(posedge clk); @(negedge clk);
    if32.tvalid = 1'b0; if32.tlast = 1'b0; if32.tuser = 1'b0;
  endtask

  task automatic send64(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    if64.tdata = d; if64.tkeep = k; if64.tlast = l; if64.tuser = u; if64.tvalid = 1'b1;
    for (int w = 0; w < 100 && !if64.tready; w++) @(negedge clk);
    if (!if64.tready) check("tready64_wait", 64'(if64.tready), 64'd1);
    @(posedge clk); @(negedge clk);
    if64.tvalid = 1'b0; if64.tlast = 1'b0; if64.tuser = 1'b0;
  endtask

  task automatic frame8_123456789();
    logic [71:0] s;
    s = 72'h313233343536373839;
    for (int i = 8; i >= 0; i--) send8(s[8*i +: 8], (i == 0), 1'b0);
  endtask

  task automatic frame32_123456789();
    send32(32'h34333231, 4'hF, 1'b0, 1'b0);
    send32(32'h38373635, 4'hF, 1'b0, 1'b0);
    send32(32'h00000039, 4'h1, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    {if8.tdata, if8.tkeep, if8.tvalid, if8.tlast, if8.tuser} = '0;
    {if32.tdata, if32.tkeep, if32.tvalid, if32.tlast, if32.tuser} = '0;
    {if64.tdata, if64.tkeep, if64.tvalid, if64.tlast, if64.tuser} = '0;
    rdy8 = 1'b1; rdy32 = 1'b1; rdy64 = 1'b1;

    // Reset state
    #2;
    check("rst_fcs",    64'(fcs32), 64'h0);
    check("rst_len",    64'(len32), 64'h0);
    check("rst_valid",  64'(val32), 64'h0);
    check("rst_bad",    64'(bad32), 64'h0);
    check("rst_frames", 64'(fr32),  64'h0);
    check("rst_tready", 64'(if32.tready), 64'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 8-bit generator: check value of "123456789"
    frame8_123456789();
    check("g8_valid", 64'(val8), 64'd1);
    check("g8_fcs",   64'(fcs8), 64'hCBF43926);
    check("g8_len",   64'(len8), 64'd9);
    check("g8_bad",   64'(bad8), 64'd0);
    @(negedge clk);
    check("g8_frames", 64'(fr8),  64'd1);
    check("g8_clear",  64'(val8), 64'd0);

    // 8-bit generator: "a" flagged with tuser
    send8(8'h61, 1'b1, 1'b1);
    check("g8_a_fcs", 64'(fcs8), 64'hE8B7BE43);
    check("g8_a_len", 64'(len8), 64'd1);
    check("g8_a_bad", 64'(bad8), 64'd1);
    @(negedge clk);
    check("g8_a_frames", 64'(fr8), 64'd2);
    check("g8_a_statbad", 64'(sb8), 64'd1);

    // 32-bit generator with a one-byte last beat
    frame32_123456789();
    check("g32_fcs", 64'(fcs32), 64'hCBF43926);
    check("g32_len", 64'(len32), 64'd9);
    check("g32_bad", 64'(bad32), 64'd0);
    @(negedge clk);
    check("g32_frames", 64'(fr32), 64'd1);

    // Empty frame: last beat with tkeep == 0 processes nothing
    send32(32'hDEADBEEF, 4'h0, 1'b1, 1'b0);
    check("g32_empty_fcs", 64'(fcs32), 64'h00000000);
    check("g32_empty_len", 64'(len32), 64'd0);
    @(negedge clk);
    check("g32_empty_frames", 64'(fr32), 64'd2);

    // Backpressure: result held, input stalled, then simultaneous accept and load
    rdy32 = 1'b0;
    frame32_123456789();
    repeat (3) @(negedge clk);
    check("bp_tready", 64'(if32.tready), 64'd0);
    check("bp_valid",  64'(val32), 64'd1);
    check("bp_fcs",    64'(fcs32), 64'hCBF43926);
    check("bp_len",    64'(len32), 64'd9);
    if32.tdata = 32'h00636261; if32.tkeep = 4'h7; if32.tlast = 1'b1; if32.tvalid = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_hold_fcs",   64'(fcs32), 64'hCBF43926);
    check("bp_hold_valid", 64'(val32), 64'd1);
    rdy32 = 1'b1;
    @(negedge clk);
    if32.tvalid = 1'b0; if32.tlast = 1'b0;
    check("b2b_valid",  64'(val32), 64'd1);
    check("b2b_fcs",    64'(fcs32), 64'h352441C2);
    check("b2b_len",    64'(len32), 64'd3);
    check("b2b_frames", 64'(fr32),  64'd3);
    @(negedge clk);
    check("b2b_clear",   64'(val32), 64'd0);
    check("b2b_frames2", 64'(fr32),  64'd4);

    // Asynchronous reset in the middle of a frame
    send32(32'h34333231, 4'hF, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_fcs",    64'(fcs32), 64'h0);
    check("arst_len",    64'(len32), 64'h0);
    check("arst_frames", 64'(fr32),  64'h0);
    check("arst_tready", 64'(if32.tready), 64'd1);
    check("arst_fr8",    64'(fr8),   64'h0);
    check("arst_sb8",    64'(sb8),   64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame32_123456789();
    check("arst_res_fcs", 64'(fcs32), 64'hCBF43926);
    check("arst_res_len", 64'(len32), 64'd9);
    @(negedge clk);
    check("arst_res_frames", 64'(fr32), 64'd1);

    // 64-bit checker: data followed by its FCS bytes 26 39 F4 CB
    send64(64'h3837363534333231, 8'hFF, 1'b0, 1'b0);
    send64(64'h000000CBF4392639, 8'h1F, 1'b1, 1'b0);
    check("c64_bad",     64'(bad64), 64'd0);
    check("c64_len",     64'(len64), 64'd13);
    check("c64_residue", 64'(fcs64), 64'hDEBB20E3);
    @(negedge clk);
    check("c64_frames", 64'(fr64), 64'd1);
    check("c64_sb0",    64'(sb64), 64'd0);

    // One data bit flipped
    send64(64'h3837363534333230, 8'hFF, 1'b0, 1'b0);
    send64(64'h000000CBF4392639, 8'h1F, 1'b1, 1'b0);
    check("c64_flip_bad", 64'(bad64), 64'd1);
    check("c64_flip_len", 64'(len64), 64'd13);
    @(negedge clk);
    check("c64_flip_sb", 64'(sb64), 64'd1);
    check("c64_flip_fr", 64'(fr64), 64'd2);

    // Frame shorter than an FCS is always bad in check mode
    send64(64'h0000000000333231, 8'h07, 1'b1, 1'b0);
    check("c64_short_bad", 64'(bad64), 64'd1);
    check("c64_short_len", 64'(len64), 64'd3);

    // Length saturation: 65536 bytes reports 16'hFFFF
    for (int i = 0; i < 8191; i++) send64(64'(i), 8'hFF, 1'b0, 1'b0);
    send64(64'h0, 8'hFF, 1'b1, 1'b0);
    check("c64_sat_len", 64'(len64), 64'hFFFF);
    check("c64_sat_valid", 64'(val64), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
